// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch - instruction fetch stage of the single-issue core.
//
// Holds the fetch PC, issues one word request at a time to instruction memory
// over a req/ack handshake, and hands each fetched instruction with its PC to
// decode through a one-entry valid/ready buffer. A one-cycle redirect from
// execute restarts fetch at a new target, flushing the buffer and discarding
// any response still in flight.
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with [1:0]!=0 halts fetch in TRAP and raises
//               misalign until an aligned redirect arrives.
//   undefined : redirect target bits [1:0] are forced to zero, no TRAP state,
//               misalign is constant 0.
//
// Ports
//   clk          in   core clock, rising edge
//   rstn         in   asynchronous active-low reset
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  [63:0] word-aligned fetch byte address
//   imem_ack     in   memory response (meaningful only while imem_req=1)
//   imem_rdata   in   [31:0] instruction word, valid when imem_req&imem_ack
//   redirect     in   one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc  in   [63:0] redirect target
//   if_valid     out  if_inst/if_pc hold a valid instruction
//   if_ready     in   decode accepts this cycle
//   if_inst      out  [31:0] instruction to decode
//   if_pc        out  [63:0] address of if_inst
//   misalign     out  misaligned redirect target detected
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_DROP, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_DROP} state_t;
`endif

  state_t      r_state,       w_state_nxt;
  logic [63:0] r_pc,          w_pc_nxt;
  logic [63:0] r_addr,        w_addr_nxt;
  logic        r_req_pending, w_pending_nxt;
  logic        r_if_valid,    w_valid_nxt;
  logic [31:0] r_if_inst,     w_inst_nxt;
  logic [63:0] r_if_pc,       w_ifpc_nxt;
  logic        r_misalign,    w_misalign_nxt;

  logic        w_req;
  logic [63:0] w_addr_out;
  logic [63:0] w_target;
  logic        w_target_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target            = redirect_pc;
  assign w_target_misaligned = |redirect_pc[1:0];
`else
  assign w_target            = redirect_pc & ~64'h3;
  assign w_target_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missed branch would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_addr_nxt     = r_addr;
    w_pending_nxt  = r_req_pending;
    w_valid_nxt    = r_if_valid;
    w_inst_nxt     = r_if_inst;
    w_ifpc_nxt     = r_if_pc;
    w_misalign_nxt = r_misalign;
    w_req          = 1'b0;
    w_addr_out     = r_addr;

    case (r_state)
      S_FETCH: begin
        // A pending request is never withdrawn, even with the buffer full.
        w_req      = !r_if_valid || if_ready || r_req_pending;
        // Fresh requests present pc combinationally; held ones replay addr.
        w_addr_out = r_req_pending ? r_addr : r_pc;
        if (w_req && !r_req_pending) w_addr_nxt = r_pc;
        w_pending_nxt = w_req && !imem_ack;

        if (redirect) begin
          w_valid_nxt    = 1'b0;
          w_pc_nxt       = w_target;
          w_misalign_nxt = w_target_misaligned;
          // A request still open must be drained before fetching the target;
          // a request acked this very cycle is simply dropped here.
          if (w_req && !imem_ack) begin
            w_state_nxt = S_DROP;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          else if (w_target_misaligned) begin
            w_state_nxt = S_TRAP;
          end
`endif
        end else if (w_req && imem_ack) begin
          // Capture wins over drain: a simultaneous transfer keeps if_valid.
          w_inst_nxt  = imem_rdata;
          w_ifpc_nxt  = w_addr_out;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + 64'd4;
        end else if (r_if_valid && if_ready) begin
          w_valid_nxt = 1'b0;
        end
      end

      S_DROP: begin
        // Hold the abandoned request until memory answers, then discard it.
        w_req         = 1'b1;
        w_addr_out    = r_addr;
        w_pending_nxt = !imem_ack;
        if (redirect) begin
          w_pc_nxt       = w_target;
          w_misalign_nxt = w_target_misaligned;
        end
        if (imem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          // r_misalign doubles as the "trap after drain" marker.
          w_state_nxt = w_misalign_nxt ? S_TRAP : S_FETCH;
`else
          w_state_nxt = S_FETCH;
`endif
        end
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: begin
        if (redirect) begin
          w_pc_nxt = w_target;
          if (!w_target_misaligned) begin
            w_state_nxt    = S_FETCH;
            w_misalign_nxt = 1'b0;
          end
        end
      end
`endif

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_req_pending <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_inst     <= NOP;
      r_if_pc       <= 64'h0;
      r_misalign    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_addr        <= w_addr_nxt;
      r_req_pending <= w_pending_nxt;
      r_if_valid    <= w_valid_nxt;
      r_if_inst     <= w_inst_nxt;
      r_if_pc       <= w_ifpc_nxt;
      r_misalign    <= w_misalign_nxt;
    end
  end

  // Reset must drop the request immediately, not at the next edge.
  assign imem_req  = w_req && rstn;
  assign imem_addr = w_addr_out;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign misalign  = r_misalign;

endmodule
